// File: rtl/apb_master_slave_sys_if.sv
// rtl/apb_master_slave_sys_if.sv - user-side request/response interface of the APB subsystem
interface apb_master_slave_sys_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                  TRANSFER;
  logic                  READ_WRITE;
  logic [ADDR_WIDTH-1:0] PADDR_IN;
  logic [DATA_WIDTH-1:0] PWDATA_IN;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;
  logic                  XFER_DONE;

  // Requester side: issues transfers and observes their results.
  modport master (
    output TRANSFER, READ_WRITE, PADDR_IN, PWDATA_IN,
    input  PRDATA, PSLVERR, XFER_DONE
  );

  // Subsystem side: accepts transfers and returns results.
  modport slave (
    input  TRANSFER, READ_WRITE, PADDR_IN, PWDATA_IN,
    output PRDATA, PSLVERR, XFER_DONE
  );

endinterface

// File: rtl/apb_master_slave_sys.sv
// rtl/apb_master_slave_sys.sv - APB master FSM with four zero-wait-state memory slaves
module apb_master_slave_sys #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 8
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  apb_master_slave_sys_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int NSLV  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  penable;
  logic [NSLV-1:0]       psel;

  logic [NSLV-1:0]       pready;
  logic [NSLV-1:0]       slv_err;
  logic [DATA_WIDTH-1:0] slv_rdata [NSLV];
  logic [DATA_WIDTH-1:0] mem [NSLV][MEM_DEPTH];

  logic                  load_req;
  logic                  xfer_cmplt;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [IDX_W-1:0]      word_idx;
  logic                  addr_hi_nz;

  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pslverr_q;
  logic                  xfer_done_q;

  // Master state register; reset aborts any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state and request acceptance: only in IDLE or at a completing ACCESS edge.
  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.TRANSFER) begin
          load_req  = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (xfer_cmplt) begin
          if (bus.TRANSFER) begin
            load_req  = 1'b1;
            state_nxt = S_SETUP;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the request so address, data and direction stay stable for the whole transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr  <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
    end else if (load_req) begin
      paddr  <= bus.PADDR_IN;
      pwdata <= bus.PWDATA_IN;
      pwrite <= bus.READ_WRITE;
    end
  end

  // Slave select decode on address bits [4:3]; selects are dead while IDLE.
  always_comb begin
    psel    = '0;
    penable = (state == S_ACCESS);
    if (state != S_IDLE) psel[paddr[4:3]] = 1'b1;
  end

  assign addr_hi_nz = |paddr[ADDR_WIDTH-1:5];
  assign word_idx   = paddr[IDX_W-1:0];

  // Per-slave response: zero wait states, error on any address above the 32-byte window.
  always_comb begin
    pready  = '0;
    slv_err = '0;
    for (int s = 0; s < NSLV; s++) begin
      pready[s]    = psel[s] & penable;
      slv_err[s]   = psel[s] & penable & addr_hi_nz;
      slv_rdata[s] = psel[s] ? mem[s][word_idx] : '0;
    end
  end

  // Collapse slave responses; unselected slaves contribute zero so an OR acts as the mux.
  always_comb begin
    sel_rdata = '0;
    for (int s = 0; s < NSLV; s++) sel_rdata = sel_rdata | slv_rdata[s];
    sel_err    = |slv_err;
    xfer_cmplt = (state == S_ACCESS) & (|pready);
  end

  // Slave storage: write on the completing edge unless the slave flagged an error.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int s = 0; s < NSLV; s++)
        for (int w = 0; w < MEM_DEPTH; w++)
          mem[s][w] <= '0;
    end else begin
      for (int s = 0; s < NSLV; s++)
        if (pready[s] && pwrite && !slv_err[s]) mem[s][word_idx] <= pwdata;
    end
  end

  // Registered user-side results; read data only changes on a completed read.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      xfer_done_q <= xfer_cmplt;
      if (xfer_cmplt) begin
        pslverr_q <= sel_err;
        if (!pwrite) prdata_q <= sel_err ? '0 : sel_rdata;
      end
    end
  end

  assign bus.PRDATA    = prdata_q;
  assign bus.PSLVERR   = pslverr_q;
  assign bus.XFER_DONE = xfer_done_q;

endmodule

// File: tb/tb_apb_master_slave_sys.sv
// tb/tb_apb_master_slave_sys.sv - self-checking bench for apb_master_slave_sys
module tb_apb_master_slave_sys;

  logic PCLK = 1'b0;
  logic PRESETn;

  apb_master_slave_sys_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_master_slave_sys #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(8)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  int          checks = 0;
  int          errors = 0;
  bit          check_en = 1'b0;

  logic [31:0] model_mem [4][8];
  logic [31:0] exp_prdata;
  bit          exp_pslverr;
  bit          exp_done;
  bit          exp_penable;
  bit          exp_pwrite;
  logic [3:0]  exp_psel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 8; w++)
        model_mem[s][w] = 32'd0;
    exp_prdata  = 32'd0;
    exp_pslverr = 1'b0;
    exp_done    = 1'b0;
    exp_penable = 1'b0;
    exp_pwrite  = 1'b0;
    exp_psel    = 4'd0;
  endtask

  function automatic int slave_of(input logic [31:0] addr);
    return int'((addr >> 3) & 32'd3);
  endfunction

  // Outcome of one finished transfer, from the address map: 32-byte window, 4 slaves of 8 words.
  task automatic model_complete(input bit rw, input logic [31:0] addr, input logic [31:0] data);
    int s;
    int w;
    bit err;
    s   = slave_of(addr);
    w   = int'(addr % 32'd8);
    err = (addr > 32'd31);
    exp_done    = 1'b1;
    exp_pslverr = err;
    if (rw) begin
      if (!err) model_mem[s][w] = data;
    end else begin
      exp_prdata = err ? 32'd0 : model_mem[s][w];
    end
  endtask

  task automatic expect_setup(input bit rw, input logic [31:0] addr);
    exp_psel    = 4'(1 << slave_of(addr));
    exp_penable = 1'b0;
    exp_pwrite  = rw;
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic drive(input bit rw, input logic [31:0] addr, input logic [31:0] data);
    bus.TRANSFER   = 1'b1;
    bus.READ_WRITE = rw;
    bus.PADDR_IN   = addr;
    bus.PWDATA_IN  = data;
  endtask

  task automatic single(input bit rw, input logic [31:0] addr, input logic [31:0] data);
    drive(rw, addr, data);
    step();
    bus.TRANSFER = 1'b0;
    exp_done = 1'b0;
    expect_setup(rw, addr);
    step();
    exp_penable = 1'b1;
    step();
    model_complete(rw, addr, data);
    exp_psel    = 4'd0;
    exp_penable = 1'b0;
    step();
    exp_done = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge PCLK) begin
    if (check_en) begin
      chk("xfer_done", 32'(bus.XFER_DONE), 32'(exp_done));
      chk("prdata", bus.PRDATA, exp_prdata);
      chk("pslverr", 32'(bus.PSLVERR), 32'(exp_pslverr));
      chk("psel", 32'(dut.psel), 32'(exp_psel));
      chk("penable", 32'(dut.penable), 32'(exp_penable));
      if (exp_psel != 4'd0) chk("pwrite", 32'(dut.pwrite), 32'(exp_pwrite));
    end
  end

  initial begin
    PRESETn        = 1'b0;
    bus.TRANSFER   = 1'b0;
    bus.READ_WRITE = 1'b0;
    bus.PADDR_IN   = 32'd0;
    bus.PWDATA_IN  = 32'd0;
    model_reset();

    #12;
    chk("rst_xfer_done", 32'(bus.XFER_DONE), 32'd0);
    chk("rst_prdata", bus.PRDATA, 32'd0);
    chk("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
    chk("rst_psel", 32'(dut.psel), 32'd0);
    chk("rst_penable", 32'(dut.penable), 32'd0);
    #10;
    PRESETn  = 1'b1;
    check_en = 1'b1;
    step();

    single(1'b0, 32'd24, 32'd0);
    chk("lit_rd24_init", bus.PRDATA, 32'd0);
    chk("lit_err24_init", 32'(bus.PSLVERR), 32'd0);

    single(1'b1, 32'd24, 32'd69);
    single(1'b0, 32'd24, 32'd0);
    chk("lit_rd24", bus.PRDATA, 32'd69);

    single(1'b1, 32'd16, 32'd9);
    single(1'b1, 32'd8, 32'd30);
    single(1'b1, 32'd1, 32'd2);
    single(1'b0, 32'd16, 32'd0);
    chk("lit_rd16", bus.PRDATA, 32'd9);
    single(1'b0, 32'd8, 32'd0);
    chk("lit_rd8", bus.PRDATA, 32'd30);
    single(1'b0, 32'd1, 32'd0);
    chk("lit_rd1", bus.PRDATA, 32'd2);
    single(1'b0, 32'd24, 32'd0);
    chk("lit_rd24_again", bus.PRDATA, 32'd69);

    single(1'b1, 32'd32, 32'd5);
    chk("lit_wr32_err", 32'(bus.PSLVERR), 32'd1);
    chk("lit_wr32_prdata_kept", bus.PRDATA, 32'd69);
    single(1'b0, 32'd32, 32'd0);
    chk("lit_rd32_data", bus.PRDATA, 32'd0);
    chk("lit_rd32_err", 32'(bus.PSLVERR), 32'd1);
    single(1'b0, 32'd0, 32'd0);
    chk("lit_rd0_untouched", bus.PRDATA, 32'd0);
    chk("lit_err_cleared", 32'(bus.PSLVERR), 32'd0);

    // Back-to-back: TRANSFER stays high; the read request is only taken at the write's completion.
    drive(1'b1, 32'd9, 32'd7);
    step();
    exp_done = 1'b0;
    expect_setup(1'b1, 32'd9);
    drive(1'b0, 32'd9, 32'd99);
    step();
    exp_penable = 1'b1;
    step();
    model_complete(1'b1, 32'd9, 32'd7);
    expect_setup(1'b0, 32'd9);
    bus.TRANSFER = 1'b0;
    chk("lit_b2b_setup", 32'(dut.psel), 32'b0010);
    step();
    exp_done    = 1'b0;
    exp_penable = 1'b1;
    step();
    model_complete(1'b0, 32'd9, 32'd0);
    exp_psel    = 4'd0;
    exp_penable = 1'b0;
    step();
    exp_done = 1'b0;
    chk("lit_b2b_rd9", bus.PRDATA, 32'd7);

    // Reset pulse in the ACCESS phase of a write.
    drive(1'b1, 32'd2, 32'hAA);
    step();
    bus.TRANSFER = 1'b0;
    exp_done = 1'b0;
    expect_setup(1'b1, 32'd2);
    step();
    exp_penable = 1'b1;
    #1;
    chk("lit_pre_rst_penable", 32'(dut.penable), 32'd1);
    PRESETn = 1'b0;
    model_reset();
    #1;
    chk("lit_rst_psel_drop", 32'(dut.psel), 32'd0);
    chk("lit_rst_penable_drop", 32'(dut.penable), 32'd0);
    @(negedge PCLK);
    #2;
    PRESETn = 1'b1;
    step();
    single(1'b0, 32'd2, 32'd0);
    chk("lit_rd2_after_rst", bus.PRDATA, 32'd0);
    single(1'b0, 32'd24, 32'd0);
    chk("lit_rd24_after_rst", bus.PRDATA, 32'd0);

    step();
    step();
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
